snitch_icache_refill_responder: RTL and testbench

//  Memory-side end of the icache refill interface: accepts line refill requests (addr, id, bypass),

---
 rtl/snitch_icache_pkg.sv | 29 ++
 rtl/snitch_icache_refill_responder_checker.sv | 22 ++
 rtl/snitch_icache_refill_responder.sv | 173 +++++++++++++++++
 tb/tb_snitch_icache_refill_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared icache configuration plus helpers that derive refill beat counts and
// address alignment from it.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned LINE_WIDTH;
    int unsigned FILL_AW;
    int unsigned FILL_DW;
    int unsigned PENDING_IW;
  } config_t;

  function automatic int unsigned refill_beats(config_t cfg);
    return cfg.LINE_WIDTH / cfg.FILL_DW;
  endfunction

  function automatic int unsigned line_align_bits(config_t cfg);
    return $clog2(cfg.LINE_WIDTH / 8);
  endfunction

  function automatic int unsigned fill_align_bits(config_t cfg);
    return $clog2(cfg.FILL_DW / 8);
  endfunction

  // Clear the low `bits` bits of a byte address.
  function automatic logic [63:0] align_addr(logic [63:0] addr, int unsigned bits);
    return addr & ~((64'd1 << bits) - 64'd1);
  endfunction

endpackage

// File: rtl/snitch_icache_refill_responder_checker.sv
// Protocol checks for the refill responder memory port; no functional logic.
module snitch_icache_refill_responder_checker #(
  parameter int unsigned FILL_AW = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic               mem_req_i,
  input logic               mem_gnt_i,
  input logic [FILL_AW-1:0] mem_addr_i,
  input logic               mem_rvalid_i,
  input logic               rvalid_expected_i
);

  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> rvalid_expected_i)
    else $error("unexpected mem_rvalid_i outside an outstanding beat");

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_i && !mem_gnt_i) |=> (mem_req_i && $stable(mem_addr_i)))
    else $error("mem_req_o/mem_addr_o changed before grant");

endmodule

// File: rtl/snitch_icache_refill_responder.sv
// Memory-side refill responder: fetches a line (or one word on bypass) as
// sequential beats from a req/gnt/rvalid port and returns it with the request id.
module snitch_icache_refill_responder
  import snitch_icache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned FILL_AW    = 32,
  parameter int unsigned FILL_DW    = 64,
  parameter int unsigned PENDING_IW = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [FILL_AW-1:0]    refill_addr_i,
  input  logic [PENDING_IW-1:0] refill_id_i,
  input  logic                  refill_bypass_i,
  input  logic                  refill_valid_i,
  output logic                  refill_ready_o,
  output logic [LINE_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_error_o,
  output logic [PENDING_IW-1:0] rsp_id_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  mem_req_o,
  output logic [FILL_AW-1:0]    mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [FILL_DW-1:0]    mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam config_t Cfg = '{LINE_WIDTH: LINE_WIDTH, FILL_AW: FILL_AW,
                              FILL_DW: FILL_DW, PENDING_IW: PENDING_IW};
  localparam int unsigned LineBeats = refill_beats(Cfg);
  localparam int unsigned CntW      = $clog2(LineBeats + 1);
  localparam int unsigned FillShift = fill_align_bits(Cfg);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [FILL_AW-1:0]    base_q, base_d;
  logic [PENDING_IW-1:0] id_q, id_d;
  logic                  bypass_q, bypass_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]       recv_cnt_q, recv_cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;

  logic [CntW-1:0] beats_s;
  logic [63:0]     line_base_s;
  logic [63:0]     fill_base_s;
  logic            beat_in_s;
  logic            rvalid_expected_s;

  assign beats_s     = bypass_q ? CntW'(1) : CntW'(LineBeats);
  assign line_base_s = align_addr(64'(refill_addr_i), line_align_bits(Cfg));
  assign fill_base_s = align_addr(64'(refill_addr_i), FillShift);

  assign mem_req_o  = (state_q == StFetch) && (issue_cnt_q < beats_s);
  assign mem_addr_o = base_q + (FILL_AW'(issue_cnt_q) << FillShift);

  // Beats beyond the refill length or outside FETCH are dropped.
  assign beat_in_s         = (state_q == StFetch) && mem_rvalid_i && (recv_cnt_q < beats_s);
  assign rvalid_expected_s = (state_q == StFetch) && (recv_cnt_q < issue_cnt_q);

  assign refill_ready_o = (state_q == StIdle);
  assign rsp_valid_o    = (state_q == StResp);
  assign rsp_data_o     = line_q;
  assign rsp_error_o    = err_q;
  assign rsp_id_o       = id_q;

  // Next-state logic for the refill FSM, counters and line assembly.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    id_d        = id_q;
    bypass_d    = bypass_q;
    err_d       = err_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    line_d      = line_q;
    case (state_q)
      StIdle: begin
        if (refill_valid_i) begin
          state_d     = StFetch;
          bypass_d    = refill_bypass_i;
          id_d        = refill_id_i;
          base_d      = refill_bypass_i ? fill_base_s[FILL_AW-1:0] : line_base_s[FILL_AW-1:0];
          err_d       = 1'b0;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StFetch: begin
        if (mem_req_o && mem_gnt_i) begin
          issue_cnt_d = issue_cnt_q + CntW'(1);
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        if (beat_in_s) begin
          err_d      = err_q | mem_err_i;
          recv_cnt_d = recv_cnt_q + CntW'(1);
          // A bypass word fills every slice, so its own slice is covered too.
          if (bypass_q) begin
            line_d = {LineBeats{mem_rdata_i}};
          end else begin
            for (int i = 0; i < LineBeats; i++) begin
              if (recv_cnt_q == CntW'(i)) begin
                line_d[i*FILL_DW +: FILL_DW] = mem_rdata_i;
              end else begin
                line_d[i*FILL_DW +: FILL_DW] = line_q[i*FILL_DW +: FILL_DW];
              end
            end
          end
          if (recv_cnt_q == beats_s - CntW'(1)) begin
            state_d = StResp;
          end else begin
            state_d = StFetch;
          end
        end else begin
          state_d = StFetch;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end else begin
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any refill in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= '0;
      id_q        <= '0;
      bypass_q    <= 1'b0;
      err_q       <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      id_q        <= id_d;
      bypass_q    <= bypass_d;
      err_q       <= err_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      line_q      <= line_d;
    end
  end

  snitch_icache_refill_responder_checker #(
    .FILL_AW(FILL_AW)
  ) i_checker (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .mem_req_i        (mem_req_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_addr_i       (mem_addr_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .rvalid_expected_i(rvalid_expected_s)
  );

endmodule

// File: tb/tb_snitch_icache_refill_responder.sv
// Directed bench for the refill responder with a 1-cycle-latency memory model.
module tb_snitch_icache_refill_responder;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [31:0]  refill_addr_i = '0;
  logic [1:0]   refill_id_i = '0;
  logic         refill_bypass_i = 1'b0;
  logic         refill_valid_i = 1'b0;
  logic         refill_ready_o;
  logic [127:0] rsp_data_o;
  logic         rsp_error_o;
  logic [1:0]   rsp_id_o;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i = 1'b1;
  logic         mem_rvalid_i = 1'b0;
  logic [63:0]  mem_rdata_i = '0;
  logic         mem_err_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat;

  logic [63:0] data_q[$];
  logic        err_q[$];
  logic [31:0] issued_q[$];
  logic        m_g;
  logic [31:0] m_a;

  snitch_icache_refill_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .refill_addr_i(refill_addr_i), .refill_id_i(refill_id_i),
    .refill_bypass_i(refill_bypass_i), .refill_valid_i(refill_valid_i),
    .refill_ready_o(refill_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o), .rsp_id_o(rsp_id_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: every granted beat returns the next queued word one cycle later.
  always begin
    @(posedge clk_i);
    m_g = rst_ni && mem_req_o && mem_gnt_i;
    m_a = mem_addr_o;
    if (m_g) issued_q.push_back(m_a);
    #1;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    if (m_g) begin
      mem_rvalid_i = 1'b1;
      if (data_q.size() > 0) begin
        mem_rdata_i = data_q.pop_front();
        mem_err_i   = err_q.pop_front();
      end else begin
        mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [63:0] d0, input logic e0, input logic [63:0] d1, input logic e1);
    data_q.delete(); err_q.delete(); issued_q.delete();
    data_q.push_back(d0); err_q.push_back(e0);
    data_q.push_back(d1); err_q.push_back(e1);
  endtask

  task automatic request(input logic [31:0] addr, input logic [1:0] id, input logic byp);
    refill_addr_i   = addr;
    refill_id_i     = id;
    refill_bypass_i = byp;
    refill_valid_i  = 1'b1;
    tick();
    refill_valid_i  = 1'b0;
  endtask

  // Latency counted in cycles from the accept cycle.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid_o && l < 30) begin
      tick();
      l++;
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid_o, 1'b0);
    chk({tag, "_ready_back"}, refill_ready_o, 1'b1);
  endtask

  initial begin
    #2;
    chk("rst_ready", refill_ready_o, 1'b1);
    chk("rst_valid", rsp_valid_o, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_data", rsp_data_o, 128'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Line refill, 0-wait grant
    load(64'hA, 1'b0, 64'hB, 1'b0);
    request(32'h0000_1004, 2'd2, 1'b0);
    chk("t1_ready_low", refill_ready_o, 1'b0);
    chk("t1_req", mem_req_o, 1'b1);
    chk("t1_addr0", mem_addr_o, 32'h0000_1000);
    wait_rsp(lat);
    chk("t1_latency", lat, 4);
    chk("t1_nbeats", issued_q.size(), 2);
    chk("t1_beat0", issued_q[0], 32'h0000_1000);
    chk("t1_beat1", issued_q[1], 32'h0000_1008);
    chk("t1_data", rsp_data_o, {64'hB, 64'hA});
    chk("t1_id", rsp_id_o, 2'd2);
    chk("t1_err", rsp_error_o, 1'b0);
    handshake("t1");

    // Bypass: single word replicated
    load(64'h1122_3344_5566_7788, 1'b0, 64'h0, 1'b0);
    request(32'h0000_100C, 2'd1, 1'b1);
    wait_rsp(lat);
    chk("t2_latency", lat, 3);
    chk("t2_nbeats", issued_q.size(), 1);
    chk("t2_beat0", issued_q[0], 32'h0000_1008);
    chk("t2_data", rsp_data_o, {64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788});
    chk("t2_id", rsp_id_o, 2'd1);
    chk("t2_req_idle", mem_req_o, 1'b0);
    handshake("t2");

    // Second beat errors, response held for 5 cycles
    load(64'hC, 1'b0, 64'hD, 1'b1);
    request(32'h0000_2010, 2'd3, 1'b0);
    wait_rsp(lat);
    chk("t3_valid", rsp_valid_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", rsp_valid_o, 1'b1);
      chk("t3_hold_data", rsp_data_o, {64'hD, 64'hC});
      chk("t3_hold_err", rsp_error_o, 1'b1);
      chk("t3_hold_id", rsp_id_o, 2'd3);
      chk("t3_hold_ready", refill_ready_o, 1'b0);
      tick();
    end
    handshake("t3");

    // Grant stalls and wrap at top of address space
    load(64'h5, 1'b0, 64'h6, 1'b0);
    mem_gnt_i = 1'b0;
    request(32'hFFFF_FFF4, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall_req", mem_req_o, 1'b1);
      chk("t4_stall_addr", mem_addr_o, 32'hFFFF_FFF0);
      if (i < 3) tick();
    end
    mem_gnt_i = 1'b1;
    wait_rsp(lat);
    chk("t4_valid", rsp_valid_o, 1'b1);
    chk("t4_nbeats", issued_q.size(), 2);
    chk("t4_beat0", issued_q[0], 32'hFFFF_FFF0);
    chk("t4_beat1", issued_q[1], 32'hFFFF_FFF8);
    chk("t4_data", rsp_data_o, {64'h6, 64'h5});
    chk("t4_err_cleared", rsp_error_o, 1'b0);
    handshake("t4");

    // Reset after the first beat; second beat returns during reset
    load(64'hE, 1'b0, 64'hF, 1'b0);
    request(32'h0000_3000, 2'd1, 1'b0);
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    chk("t5_ready", refill_ready_o, 1'b1);
    chk("t5_valid", rsp_valid_o, 1'b0);
    chk("t5_req", mem_req_o, 1'b0);
    chk("t5_data", rsp_data_o, 128'd0);
    chk("t5_id", rsp_id_o, 2'd0);
    chk("t5_err", rsp_error_o, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    chk("t5_idle_ready", refill_ready_o, 1'b1);
    chk("t5_idle_valid", rsp_valid_o, 1'b0);
    chk("t5_idle_req", mem_req_o, 1'b0);

    load(64'h1, 1'b0, 64'h2, 1'b0);
    request(32'h0000_4008, 2'd3, 1'b0);
    wait_rsp(lat);
    chk("t6_latency", lat, 4);
    chk("t6_beat0", issued_q[0], 32'h0000_4000);
    chk("t6_data", rsp_data_o, {64'h2, 64'h1});
    chk("t6_id", rsp_id_o, 2'd3);
    handshake("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
